sid_filter_sched: RTL and testbench

Time-multiplexes the single `sid_filter` datapath between `N_SID` emulated SID chips. On each SID-cycle `tick`, it runs the filter's 7-stage pipeline once per chip, in ascending chip order. It presents each chip's configuration and stored integrator state to the datapath, then writes back the updated state and captures each chip's audio. It sits between the per-chip register/voice front ends and `sid_filter`, and drives the filter's `stage` input.

---
 rtl/sid_pkg.sv | 46 ++++
 rtl/sid_filter_state_store.sv | 31 +++
 rtl/sid_filter_sched.sv | 116 +++++++++++
 tb/tb_sid_filter_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared SID types and filter scheduler constants
package sid;

  typedef logic signed [23:0] s24_t;

  typedef enum logic {
    MODEL_6581 = 1'b0,
    MODEL_8580 = 1'b1
  } model_t;

  // Filter integrator state carried between SID cycles
  typedef struct packed {
    s24_t vlp;
    s24_t vbp;
    s24_t vhp;
  } filter_v_t;

  // Everything the filter datapath needs for one chip
  typedef struct packed {
    model_t    model;
    logic [10:0] fc;
    logic [3:0]  res;
    logic [3:0]  filt;
    logic [3:0]  mode;
    logic [3:0]  vol;
    s24_t      voice1;
    s24_t      voice2;
    s24_t      voice3;
    filter_v_t state;
  } filter_i_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } filter_sched_state_t;

  // Seven pipeline stages plus one capture slot per chip
  localparam int FILTER_SLOTS = 8;
  localparam int SID_MAX      = 4;

  // Index width for a chip count, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sid_filter_state_store.sv
// rtl/sid_filter_state_store.sv - per-chip filter integrator state register file
module sid_filter_state_store
  import sid::*;
#(
  parameter int N_SID = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [idx_width(N_SID)-1:0] waddr,
  input  filter_v_t                   wdata,
  input  logic [idx_width(N_SID)-1:0] raddr,
  output filter_v_t                   rdata
);

  filter_v_t mem [N_SID];

  // Single write port; all entries clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SID; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sid_filter_sched.sv
// rtl/sid_filter_sched.sv - time-multiplexes one sid_filter datapath across N_SID chips
module sid_filter_sched
  import sid::*;
#(
  parameter int N_SID = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  filter_i_t   req_i [N_SID],
  output filter_i_t   filter_o,
  output logic [2:0]  stage_o,
  input  filter_v_t   state_i,
  input  s24_t        audio_i,
  output s24_t        audio_o [N_SID],
  output logic        audio_valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i
);

  localparam int AW = idx_width(N_SID);
  localparam logic [AW-1:0] LAST_CHIP  = AW'(N_SID - 1);
  localparam logic [2:0]    LAST_STAGE = 3'(FILTER_SLOTS - 1);

  filter_sched_state_t st;
  logic [2:0]    slot;
  logic [AW-1:0] active;
  logic          pending;
  filter_v_t     rd_state;
  logic          store_we;

  // Integrator state is written back only when stage 7 completes
  assign store_we = (st == RUN) && (slot == LAST_STAGE);

  sid_filter_state_store #(
    .N_SID(N_SID)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (store_we),
    .waddr (active),
    .wdata (state_i),
    .raddr (active),
    .rdata (rd_state)
  );

  // Present the active chip's config with its own stored integrator state
  always_comb begin
    filter_o       = req_i[active];
    filter_o.state = rd_state;
  end

  // slot is held at 0 while idle, so it doubles as the stage index
  assign stage_o = slot;
  assign busy_o  = (st == RUN);

  // Sequencer, tick queueing, overrun flag and audio capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      slot          <= 3'd0;
      active        <= '0;
      pending       <= 1'b0;
      overrun_o     <= 1'b0;
      audio_valid_o <= 1'b0;
      for (int i = 0; i < N_SID; i++) begin
        audio_o[i] <= '0;
      end
    end else begin
      audio_valid_o <= 1'b0;

      // A tick arriving while one is already queued is lost; clear wins
      if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end else if (tick && (st == RUN) && pending) begin
        overrun_o <= 1'b1;
      end

      case (st)
        IDLE: begin
          if (tick || pending) begin
            st     <= RUN;
            active <= '0;
            slot   <= 3'd1;
          end
          pending <= 1'b0;
        end
        RUN: begin
          if (slot == 3'd0) begin
            audio_o[active] <= audio_i;
            if (active == LAST_CHIP) begin
              audio_valid_o <= 1'b1;
              active        <= '0;
              pending       <= 1'b0;
              if (tick || pending) begin
                slot <= 3'd1;
              end else begin
                st <= IDLE;
              end
            end else begin
              active <= active + 1'b1;
              slot   <= 3'd1;
              if (tick) pending <= 1'b1;
            end
          end else begin
            slot <= slot + 3'd1;
            if (tick) pending <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_filter_sched.sv
// tb/tb_sid_filter_sched.sv - self-checking bench for sid_filter_sched
module tb_sid_filter_sched;
  import sid::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  filter_i_t  req [N];
  filter_i_t  fo;
  logic [2:0] stage;
  filter_v_t  st_in;
  s24_t       aud_in;
  s24_t       aud_out [N];
  logic       valid;
  logic       busy;
  logic       ovr;

  always #5 clk = ~clk;

  sid_filter_sched #(.N_SID(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .req_i         (req),
    .filter_o      (fo),
    .stage_o       (stage),
    .state_i       (st_in),
    .audio_i       (aud_in),
    .audio_o       (aud_out),
    .audio_valid_o (valid),
    .busy_o        (busy),
    .overrun_o     (ovr),
    .overrun_clr_i (clr)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: sequences described by their start cycle
  int        cyc = 0;
  bit        m_in_seq = 0;
  int        m_s = 0;
  bit        m_pend = 0;
  bit        m_ovr = 0;
  bit        m_valid = 0;
  filter_v_t m_store [N];
  s24_t      m_aud [N];

  int tick_at [$];
  int clr_at [$];
  int rst_at = -1;
  int rnd_pct = 0;
  bit det = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic filter_i_t rand_req();
    filter_i_t r;
    r.model  = model_t'($urandom_range(1));
    r.fc     = 11'($urandom);
    r.res    = 4'($urandom);
    r.filt   = 4'($urandom);
    r.mode   = 4'($urandom);
    r.vol    = 4'($urandom);
    r.voice1 = s24_t'($urandom);
    r.voice2 = s24_t'($urandom);
    r.voice3 = s24_t'($urandom);
    r.state  = '{vlp: s24_t'($urandom), vbp: s24_t'($urandom), vhp: s24_t'($urandom)};
    return r;
  endfunction

  function automatic int m_chip();
    return m_in_seq ? (cyc - m_s) / FILTER_SLOTS : 0;
  endfunction

  function automatic int m_stage();
    return m_in_seq ? (((cyc - m_s) % FILTER_SLOTS) + 1) % FILTER_SLOTS : 0;
  endfunction

  task automatic m_reset();
    m_in_seq = 0;
    m_pend   = 0;
    m_ovr    = 0;
    m_valid  = 0;
    for (int k = 0; k < N; k++) begin
      m_store[k] = '0;
      m_aud[k]   = '0;
    end
  endtask

  task automatic check_outputs(input string ph);
    filter_i_t e;
    int ch;
    ch = m_chip();
    e = req[ch];
    e.state = m_store[ch];
    chk({ph, "_stage"}, 256'(stage), 256'(m_stage()));
    chk({ph, "_busy"}, 256'(busy), 256'(m_in_seq));
    chk({ph, "_valid"}, 256'(valid), 256'(m_valid));
    chk({ph, "_overrun"}, 256'(ovr), 256'(m_ovr));
    chk({ph, "_filter_o"}, 256'(fo), 256'(e));
    for (int k = 0; k < N; k++) begin
      chk({ph, "_audio_o"}, 256'(aud_out[k]), 256'(m_aud[k]));
    end
  endtask

  // Expected effect of the clock edge ending cycle cyc
  task automatic m_edge();
    bit ovs;
    bit nv;
    int o;
    int ch;
    ovs = tick && m_in_seq && m_pend;
    nv  = 0;
    if (m_in_seq) begin
      o  = cyc - m_s;
      ch = o / FILTER_SLOTS;
      if (o % FILTER_SLOTS == 6) m_store[ch] = st_in;
      if (o % FILTER_SLOTS == 7) m_aud[ch] = aud_in;
      if (o == FILTER_SLOTS * N - 1) begin
        nv = 1;
        if (tick || m_pend) m_s = cyc + 1;
        else m_in_seq = 0;
        m_pend = 0;
      end else if (tick) begin
        m_pend = 1;
      end
    end else if (tick || m_pend) begin
      m_in_seq = 1;
      m_s      = cyc + 1;
      m_pend   = 0;
    end
    m_valid = nv;
    if (clr) m_ovr = 0;
    else if (ovs) m_ovr = 1;
  endtask

  task automatic run(input int n, input string ph);
    int ch;
    repeat (n) begin
      tick = in_q(tick_at, cyc) || (rnd_pct > 0 && $urandom_range(99) < rnd_pct);
      clr  = in_q(clr_at, cyc) || (rnd_pct > 0 && $urandom_range(99) < 3);
      for (int k = 0; k < N; k++) req[k] = rand_req();
      ch = m_chip();
      if (det) begin
        req[0].model = MODEL_6581;
        req[1].model = MODEL_8580;
        st_in  = '{vlp: s24_t'(ch + 1), vbp: s24_t'(ch + 2), vhp: s24_t'(ch + 3)};
        aud_in = s24_t'(100 + ch);
      end else begin
        st_in  = '{vlp: s24_t'($urandom), vbp: s24_t'($urandom), vhp: s24_t'($urandom)};
        aud_in = s24_t'($urandom);
      end
      if (cyc == rst_at) begin
        tick  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stage", 256'(stage), 256'(0));
        chk("async_rst_busy", 256'(busy), 256'(0));
        chk("async_rst_valid", 256'(valid), 256'(0));
        chk("async_rst_overrun", 256'(ovr), 256'(0));
        chk("async_rst_state", 256'(fo.state), 256'(0));
        for (int k = 0; k < N; k++) chk("async_rst_audio", 256'(aud_out[k]), 256'(0));
        m_reset();
      end
      @(negedge clk);
      check_outputs(ph);
      if (rst_n) m_edge();
      @(posedge clk);
      #1;
      if (!rst_n) rst_n = 1'b1;
      cyc++;
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) req[k] = rand_req();
    st_in  = '0;
    aud_in = '0;
    m_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_stage", 256'(stage), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_valid", 256'(valid), 256'(0));
    chk("reset_overrun", 256'(ovr), 256'(0));
    for (int k = 0; k < N; k++) chk("reset_audio", 256'(aud_out[k]), 256'(0));
    rst_n = 1'b1;
    cyc = 0;

    // Single tick with the deterministic datapath stub
    det = 1'b1;
    tick_at.push_back(cyc);
    run(20, "single");

    // Second tick queued mid-sequence: back-to-back run, no overrun
    tick_at.push_back(cyc);
    tick_at.push_back(cyc + 5);
    run(40, "pending");

    // Third tick overruns; clear together with another overrun
    tick_at.push_back(cyc);
    tick_at.push_back(cyc + 5);
    tick_at.push_back(cyc + 9);
    tick_at.push_back(cyc + 12);
    clr_at.push_back(cyc + 12);
    run(40, "overrun");

    // Reset mid-sequence with overrun set and store populated
    tick_at.push_back(cyc);
    tick_at.push_back(cyc + 2);
    tick_at.push_back(cyc + 4);
    rst_at = cyc + 11;
    tick_at.push_back(cyc + 20);
    run(50, "midreset");

    // Random ticks, clears and datapath values
    det = 1'b0;
    rnd_pct = 6;
    run(3000, "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
